// File: rtl/i2s_receptor.sv
// i2s_receptor
// I2S slave receiver. Oversamples the codec's SCLK/LRCLK/SDOUT in the system
// clock domain and deserializes stereo PCM into parallel left/right words.
// The output is a pair-wide valid/ready stream.
//
// Ports:
//   clk         system clock, all logic on the rising edge
//   reset       asynchronous reset, active low (0 = reset)
//   SCLK        I2S bit clock from the codec (asynchronous)
//   LRCLK       word select from the codec (asynchronous), 0 = left, 1 = right
//   SDOUT       serial data from the codec (asynchronous), MSB first
//   left_data   captured left word
//   right_data  captured right word
//   valid       a pair is available, held until accepted
//   ready       consumer accepts the pair when valid & ready at a clk edge
//   overrun     sticky, a completed pair was dropped while valid was pending

module i2s_receptor #(
   parameter int WIDTH = 24
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             SCLK,
   input  logic             LRCLK,
   input  logic             SDOUT,
   output logic [WIDTH-1:0] left_data,
   output logic [WIDTH-1:0] right_data,
   output logic             valid,
   input  logic             ready,
   output logic             overrun
);

   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] FULL = CW'(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {ALIGN, LEFT, RIGHT} state_t;

   state_t state_q, state_d;

   logic sclk_s1, sclk_s2, sclk_s3;
   logic lr_s1, lr_s2;
   logic sd_s1, sd_s2;
   logic prev_lr;
   logic [CW-1:0] cnt;
   logic [WIDTH-1:0] shift;
   logic [WIDTH-1:0] left_word;
   logic left_ok;

   logic bit_event, chan_start, word_bit, word_done;
   logic left_done, pair_done;
   logic [WIDTH-1:0] full_word;

   // Two-stage synchronizers for all codec pins, plus a third SCLK stage
   // so a rising edge of the synchronized bit clock can be detected.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sclk_s1 <= 1'b0;
         sclk_s2 <= 1'b0;
         sclk_s3 <= 1'b0;
         lr_s1   <= 1'b0;
         lr_s2   <= 1'b0;
         sd_s1   <= 1'b0;
         sd_s2   <= 1'b0;
      end else begin
         sclk_s1 <= SCLK;
         sclk_s2 <= sclk_s1;
         sclk_s3 <= sclk_s2;
         lr_s1   <= LRCLK;
         lr_s2   <= lr_s1;
         sd_s1   <= SDOUT;
         sd_s2   <= sd_s1;
      end
   end

   // A word-select change marks the I2S delay slot, which still carries the
   // previous word's tail and is therefore never shifted in. The counter
   // saturates at WIDTH so surplus slots in a long channel are ignored.
   always_comb begin
      bit_event  = sclk_s2 & ~sclk_s3;
      chan_start = bit_event && (lr_s2 != prev_lr);
      word_bit   = bit_event && !chan_start && (cnt < FULL);
      word_done  = word_bit && (cnt == LAST);
      full_word  = {shift[WIDTH-2:0], sd_s2};
      left_done  = word_done && (state_q == LEFT);
      pair_done  = word_done && (state_q == RIGHT) && left_ok;
   end

   // Channel tracking. Out of reset we wait in ALIGN for a left channel start
   // so that a frame is never assembled from a partial right word.
   always_comb begin
      state_d = state_q;
      if (chan_start) begin
         if (!lr_s2) begin
            state_d = LEFT;
         end else if (state_q != ALIGN) begin
            state_d = RIGHT;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ALIGN;
      end else begin
         state_q <= state_d;
      end
   end

   // Bit collection. left_ok is dropped when a new left channel begins or when
   // any channel is cut short, so a pair is only built from two whole words
   // of the same frame.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         prev_lr   <= 1'b0;
         cnt       <= '0;
         shift     <= '0;
         left_word <= '0;
         left_ok   <= 1'b0;
      end else begin
         if (bit_event) begin
            prev_lr <= lr_s2;
         end
         if (chan_start) begin
            cnt <= '0;
         end else if (word_bit) begin
            shift <= full_word;
            cnt   <= cnt + CW'(1);
         end
         if (left_done) begin
            left_word <= full_word;
         end
         if (chan_start && (!lr_s2 || (cnt < FULL))) begin
            left_ok <= 1'b0;
         end else if (left_done) begin
            left_ok <= 1'b1;
         end
      end
   end

   // Output stream. A completing pair may replace the pending one only when
   // that one is being accepted on the same edge; otherwise the new pair is
   // dropped and the sticky overrun flag records it.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         left_data  <= '0;
         right_data <= '0;
         valid      <= 1'b0;
         overrun    <= 1'b0;
      end else begin
         if (pair_done) begin
            if (!valid || ready) begin
               left_data  <= left_word;
               right_data <= full_word;
               valid      <= 1'b1;
            end else begin
               overrun <= 1'b1;
            end
         end else if (valid && ready) begin
            valid <= 1'b0;
         end
      end
   end

endmodule
